minimax_wb: RTL and testbench

//  Writeback stage directly upstream of the minimax register file: merges ALU results and

---
 rtl/minimax_wb_pkg.sv | 42 ++++
 rtl/minimax_ld_fifo.sv | 85 ++++++++
 rtl/minimax_wb.sv | 126 ++++++++++++
 tb/tb_minimax_wb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/minimax_wb_pkg.sv
// -----------------------------------------------------------------------------
// minimax_wb_pkg
//   Shared definitions for the minimax writeback stage:
//   - LOAD funct3 encodings (F3_LB .. F3_LHU)
//   - ld_entry_t: one tracked outstanding load {rd, funct3, offset}
//   - load_extend(): lane select plus sign/zero extension of a returned word
// -----------------------------------------------------------------------------
package minimax_wb_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [1:0] offset;
   } ld_entry_t;

   // Byte lane follows offset[1:0]; half lane follows offset[1] only.
   // Reserved encodings (011, 110, 111) fall through to a full-word load.
   function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                               input logic [1:0]  offset,
                                               input logic [31:0] rdata);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      shifted = rdata >> {offset, 3'b000};
      b       = shifted[7:0];
      h       = offset[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   return {{24{b[7]}}, b};
         F3_LBU:  return {24'h0, b};
         F3_LH:   return {{16{h[15]}}, h};
         F3_LHU:  return {16'h0, h};
         default: return rdata;
      endcase
   endfunction

endpackage

// File: rtl/minimax_ld_fifo.sv
// -----------------------------------------------------------------------------
// minimax_ld_fifo
//   In-order tracker of outstanding loads. DEPTH-entry synchronous FIFO of
//   ld_entry_t, exposing the head entry plus every slot's rd and valid bit so
//   the writeback stage can compare against all pending destinations.
// Ports
//   clk, reset     clock, synchronous active-high reset
//   push, push_entry  enqueue one load (caller guarantees !full)
//   pop            dequeue head (caller guarantees !empty)
//   full, empty    occupancy flags
//   head           oldest entry
//   entry_valid    per-slot occupancy
//   entry_rd       per-slot destination register
// -----------------------------------------------------------------------------
module minimax_ld_fifo
   import minimax_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  ld_entry_t             push_entry,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output ld_entry_t             head,
   output logic [DEPTH-1:0]      entry_valid,
   output logic [DEPTH-1:0][4:0] entry_rd
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   ld_entry_t              mem [DEPTH];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [CNT_W-1:0]       count;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         entry_valid <= '0;
      end else begin
         // Clear before set: a same-slot pop+push leaves the slot valid.
         if (pop) begin
            rd_ptr              <= ptr_inc(rd_ptr);
            entry_valid[rd_ptr] <= 1'b0;
         end
         if (push) begin
            wr_ptr              <= ptr_inc(wr_ptr);
            entry_valid[wr_ptr] <= 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: payload storage has no reset; entry_valid and count alone define
   // which slots are meaningful, so the array maps onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) entry_rd[i] = mem[i].rd;
   end

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/minimax_wb.sv
// -----------------------------------------------------------------------------
// minimax_wb
//   Writeback stage feeding the minimax register file. Merges ALU results and
//   returned loads into one registered write port, tracks outstanding loads in
//   issue order, aligns/extends load data and flags decode read hazards.
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   ld_issue/ld_ready/ld_rd/ld_funct3/ld_offset   load issue handshake
//   mem_rvalid/mem_rdata            in-order load responses, no backpressure
//   rs_a, rs_b / hazard             decode source registers / stall request
//   wb_we/wb_addr/wb_data           registered RF write port
//   ld_pending                      tracker non-empty
//   err_unexpected                  sticky: response arrived with empty tracker
// -----------------------------------------------------------------------------
module minimax_wb
   import minimax_wb_pkg::*;
#(
   parameter int LD_DEPTH = 2,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_issue,
   output logic            ld_ready,
   input  logic [4:0]      ld_rd,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_offset,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [4:0]      rs_a,
   input  logic [4:0]      rs_b,
   output logic            hazard,
   output logic            wb_we,
   output logic [4:0]      wb_addr,
   output logic [XLEN-1:0] wb_data,
   output logic            ld_pending,
   output logic            err_unexpected
);

   logic                     full;
   logic                     empty;
   logic                     push;
   logic                     pop;
   ld_entry_t                head;
   logic [LD_DEPTH-1:0]      entry_valid;
   logic [LD_DEPTH-1:0][4:0] entry_rd;

   logic alu_rd_owed;
   logic rs_a_owed;
   logic rs_b_owed;
   logic alu_fire;

   // A response that arrives while the tracker is empty is never popped, even
   // if a load is pushed in the same cycle: that entry is not yet visible.
   assign pop      = mem_rvalid & ~empty;
   assign ld_ready = ~full;
   assign push     = ld_issue & ld_ready;

   minimax_ld_fifo #(
      .DEPTH (LD_DEPTH)
   ) u_ld_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (push),
      .push_entry  ('{rd: ld_rd, funct3: ld_funct3, offset: ld_offset}),
      .pop         (pop),
      .full        (full),
      .empty       (empty),
      .head        (head),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned and infers a latch.
   always_comb begin
      alu_rd_owed = 1'b0;
      rs_a_owed   = 1'b0;
      rs_b_owed   = 1'b0;
      for (int i = 0; i < LD_DEPTH; i++) begin
         if (entry_valid[i] && entry_rd[i] == alu_rd) alu_rd_owed = 1'b1;
         if (entry_valid[i] && entry_rd[i] == rs_a)   rs_a_owed   = 1'b1;
         if (entry_valid[i] && entry_rd[i] == rs_b)   rs_b_owed   = 1'b1;
      end
   end

   // Load responses own the port; an ALU write to a register still owed by an
   // older load waits so the load cannot overwrite it afterwards.
   assign alu_ready = ~(mem_rvalid & ~empty) & ~((alu_rd != 5'd0) & alu_rd_owed);
   assign alu_fire  = alu_valid & alu_ready;

   // Hazard also covers the value sitting in the writeback register, which the
   // register file has not absorbed yet.
   assign hazard = ((rs_a != 5'd0) && (rs_a_owed || (wb_we && rs_a == wb_addr))) ||
                   ((rs_b != 5'd0) && (rs_b_owed || (wb_we && rs_b == wb_addr)));

   assign ld_pending = ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_we          <= 1'b0;
         wb_addr        <= '0;
         wb_data        <= '0;
         err_unexpected <= 1'b0;
      end else begin
         wb_we <= 1'b0;
         // x0 writes are consumed normally but never enabled.
         if (pop) begin
            wb_we   <= (head.rd != 5'd0);
            wb_addr <= head.rd;
            wb_data <= load_extend(head.funct3, head.offset, mem_rdata);
         end else if (alu_fire) begin
            wb_we   <= (alu_rd != 5'd0);
            wb_addr <= alu_rd;
            wb_data <= alu_data;
         end
         if (mem_rvalid && empty) err_unexpected <= 1'b1;
      end
   end

endmodule

// File: tb/tb_minimax_wb.sv
// -----------------------------------------------------------------------------
// tb_minimax_wb
//   Directed and randomized stimulus for minimax_wb, checked cycle by cycle
//   against a queue-based behavioural model of the writeback stage.
// -----------------------------------------------------------------------------
module tb_minimax_wb;

   localparam int LD_DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_issue;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_offset;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [4:0]  rs_a;
   logic [4:0]  rs_b;
   logic        hazard;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ld_pending;
   logic        err_unexpected;

   minimax_wb #(
      .LD_DEPTH (LD_DEPTH),
      .XLEN     (32)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_rd         (alu_rd),
      .alu_data       (alu_data),
      .ld_issue       (ld_issue),
      .ld_ready       (ld_ready),
      .ld_rd          (ld_rd),
      .ld_funct3      (ld_funct3),
      .ld_offset      (ld_offset),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .rs_a           (rs_a),
      .rs_b           (rs_b),
      .hazard         (hazard),
      .wb_we          (wb_we),
      .wb_addr        (wb_addr),
      .wb_data        (wb_data),
      .ld_pending     (ld_pending),
      .err_unexpected (err_unexpected)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0] rd;
      logic [2:0] f3;
      logic [1:0] off;
   } m_ld_t;

   m_ld_t       m_q[$];
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        m_err;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
      logic [31:0] v;
      case (f3)
         3'd0, 3'd4: begin
            v = (w >> (8 * int'(off))) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
         end
         3'd1, 3'd5: begin
            v = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic in_q(input logic [4:0] r);
      foreach (m_q[i]) if (m_q[i].rd == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic ref_hz(input logic [4:0] r);
      return (r != 5'd0) && (in_q(r) || (m_we && r == m_addr));
   endfunction

   // One clock: check combinational outputs for the current inputs, advance
   // the model, then check registered outputs just after the edge.
   task automatic cycle();
      logic  e_pending, e_ld_ready, e_alu_ready, e_hazard;
      m_ld_t e;
      #1;
      e_pending   = (m_q.size() != 0);
      e_ld_ready  = (m_q.size() < LD_DEPTH);
      e_alu_ready = !(mem_rvalid && e_pending) && !(alu_rd != 5'd0 && in_q(alu_rd));
      e_hazard    = ref_hz(rs_a) || ref_hz(rs_b);
      check("ld_pending", 32'(ld_pending), 32'(e_pending));
      check("ld_ready",   32'(ld_ready),   32'(e_ld_ready));
      check("alu_ready",  32'(alu_ready),  32'(e_alu_ready));
      check("hazard",     32'(hazard),     32'(e_hazard));
      if (mem_rvalid && e_pending) begin
         e      = m_q.pop_front();
         m_we   = (e.rd != 5'd0);
         m_addr = e.rd;
         m_data = ref_load(e.f3, e.off, mem_rdata);
      end else if (alu_valid && e_alu_ready) begin
         m_we   = (alu_rd != 5'd0);
         m_addr = alu_rd;
         m_data = alu_data;
      end else begin
         m_we = 1'b0;
      end
      if (mem_rvalid && !e_pending) m_err = 1'b1;
      if (ld_issue && e_ld_ready) m_q.push_back('{ld_rd, ld_funct3, ld_offset});
      @(posedge clk);
      #1;
      check("wb_we",          32'(wb_we),          32'(m_we));
      check("wb_addr",        32'(wb_addr),        32'(m_addr));
      check("wb_data",        wb_data,             m_data);
      check("err_unexpected", 32'(err_unexpected), 32'(m_err));
   endtask

   task automatic idle();
      alu_valid  = 1'b0; alu_rd   = 5'd0; alu_data  = 32'h0;
      ld_issue   = 1'b0; ld_rd    = 5'd0; ld_funct3 = 3'd0; ld_offset = 2'd0;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      rs_a       = 5'd0; rs_b     = 5'd0;
   endtask

   task automatic reset_dut();
      idle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_q.delete();
      m_we = 1'b0; m_addr = 5'd0; m_data = 32'h0; m_err = 1'b0;
      check("rst_wb_we",   32'(wb_we),          32'd0);
      check("rst_wb_addr", 32'(wb_addr),        32'd0);
      check("rst_wb_data", wb_data,             32'd0);
      check("rst_err",     32'(err_unexpected), 32'd0);
      check("rst_pending", 32'(ld_pending),     32'd0);
   endtask

   task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
      ld_issue = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_offset = off;
   endtask

   task automatic respond(input logic [31:0] w);
      mem_rvalid = 1'b1; mem_rdata = w;
   endtask

   logic [2:0]  t2_f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b010};
   logic [1:0]  t2_off [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
   logic [31:0] t2_w   [4] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000};
   logic [31:0] t2_exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h8001_0000};

   initial begin
      reset = 1'b1;
      idle();
      reset_dut();

      // ALU-only write
      idle(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
      cycle();
      check("t1_we",   32'(wb_we),   32'd1);
      check("t1_addr", 32'(wb_addr), 32'd5);
      check("t1_data", wb_data,      32'h1234);
      idle(); cycle();

      // Load lane extraction and extension
      for (int i = 0; i < 4; i++) begin
         idle(); issue(5'd7, t2_f3[i], t2_off[i]); cycle();
         idle(); respond(t2_w[i]); cycle();
         check("t2_load", wb_data, t2_exp[i]);
      end

      // Load response and ALU collide
      idle(); issue(5'd3, 3'b010, 2'd0); cycle();
      idle(); respond(32'hAAAA_5555);
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
      cycle();
      check("t3_ld_addr", 32'(wb_addr), 32'd3);
      mem_rvalid = 1'b0; cycle();
      check("t3_alu_addr", 32'(wb_addr), 32'd4);
      idle(); cycle();

      // Hazard tracking on x9, WAW stall of ALU to x9
      idle(); issue(5'd9, 3'b010, 2'd0); rs_a = 5'd9; cycle();
      idle(); rs_a = 5'd9; alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99; cycle();
      idle(); rs_a = 5'd9; respond(32'h0000_0909); cycle();
      idle(); rs_a = 5'd9; cycle();
      idle(); rs_a = 5'd9; cycle();
      idle(); issue(5'd0, 3'b010, 2'd0); cycle();
      idle(); respond(32'h1111_1111); cycle();
      idle(); cycle();

      // Fill tracker, push+pop, ordering across pointer wrap
      idle(); issue(5'd10, 3'b010, 2'd0); cycle();
      idle(); issue(5'd11, 3'b010, 2'd0); cycle();
      idle(); issue(5'd12, 3'b010, 2'd0); cycle();
      check("t5_full", 32'(ld_ready), 32'd0);
      idle(); respond(32'hA); cycle();
      idle(); respond(32'hB); issue(5'd13, 3'b000, 2'd1); cycle();
      for (int i = 0; i < 6; i++) begin
         idle(); issue(5'(16 + i), 3'b010, 2'd0);
         if (m_q.size() != 0) respond($urandom);
         cycle();
      end
      while (m_q.size() != 0) begin
         idle(); respond($urandom); cycle();
      end

      // Push into empty tracker with same-cycle response
      idle(); issue(5'd14, 3'b010, 2'd0); respond(32'hDEAD_BEEF); cycle();
      idle(); respond(32'h0000_0E0E); cycle();
      reset_dut();

      // Mid-operation reset discards pending loads
      idle(); issue(5'd20, 3'b010, 2'd0); cycle();
      idle(); issue(5'd21, 3'b010, 2'd0); cycle();
      reset_dut();
      idle(); respond(32'h1234_5678); cycle();
      check("t6_err", 32'(err_unexpected), 32'd1);
      check("t6_we",  32'(wb_we),          32'd0);
      idle(); cycle();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         idle();
         alu_valid = 1'($urandom_range(0, 1));
         alu_rd    = 5'($urandom_range(0, 7));
         alu_data  = $urandom;
         if ($urandom_range(0, 2) == 0)
            issue(5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         if (m_q.size() != 0 && $urandom_range(0, 2) != 0) respond($urandom);
         rs_a = 5'($urandom_range(0, 7));
         rs_b = 5'($urandom_range(0, 7));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
